// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg : shared constants and scan-state encoding for the 7-seg scanner
// Revision : 1.0
// ============================================================================
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Bus positions of each segment; a is the MSB of seg
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// seg7_decode : combinational BCD to 7-segment decoder, non-BCD codes dark
// Revision    : 1.0
// ============================================================================
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // pat is written in a..g order and then placed onto the bus positions
  logic [6:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    case (bcd)
      4'd0: pat = 7'b1111110;
      4'd1: pat = 7'b0110000;
      4'd2: pat = 7'b1101101;
      4'd3: pat = 7'b1111001;
      4'd4: pat = 7'b0110011;
      4'd5: pat = 7'b1011011;
      4'd6: pat = 7'b1011111;
      4'd7: pat = 7'b1110000;
      4'd8: pat = 7'b1111111;
      4'd9: pat = 7'b1111011;
      default: pat = SEG_BLANK;
    endcase
  end

  assign seg[SEG_A] = pat[6];
  assign seg[SEG_B] = pat[5];
  assign seg[SEG_C] = pat[4];
  assign seg[SEG_D] = pat[3];
  assign seg[SEG_E] = pat[2];
  assign seg[SEG_F] = pat[1];
  assign seg[SEG_G] = pat[0];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// seg7_scan_ctrl : N-digit multiplexed 7-segment scanner with frame-aligned
//                  word updates, inter-digit blanking and leading-zero blanking
// Revision       : 1.0
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    lzb_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_tick
);

  localparam int IDX_W       = $clog2(N_DIGITS);
  localparam int CNT_W       = $clog2(SLOT_CYCLES + 1);
  localparam int SHOW_CYCLES = SLOT_CYCLES - BLANK_CYCLES;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam state_t           SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic                    tick_q, tick_d;
  logic [4*N_DIGITS-1:0]   act_bcd_q, act_bcd_d;
  logic [N_DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [4*N_DIGITS-1:0]   pend_bcd_q, pend_bcd_d;
  logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                    pend_q, pend_d;

  logic                    wrap;
  logic                    commit;
  logic                    show;
  logic                    higher_blank;
  logic [N_DIGITS-1:0]     lz_blank;
  logic [3:0]              cur_bcd;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [6:0]              dec_seg;

  // Blanking propagates downward from the most significant digit; digit 0 is exempt
  always_comb begin
    higher_blank = lzb_en;
    lz_blank     = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      higher_blank = higher_blank & (act_bcd_q[4*k +: 4] == 4'd0);
      lz_blank[k]  = higher_blank;
    end
  end

  always_comb begin
    cur_bcd   = 4'hF;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_bcd   = act_bcd_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_blank = lz_blank[k];
      end
    end
  end

  seg7_decode u_decode (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SLOT_START;
          idx_d   = '0;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = SLOT_START;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign show   = (state_q == SHOW);
  assign an_d   = show ? (N_DIGITS'(1) << idx_q) : '0;
  assign seg_d  = (show && !cur_blank) ? dec_seg : SEG_BLANK;
  assign dp_d   = show & cur_dp;
  assign tick_d = wrap;

  // A pending word only becomes visible when no partially-drawn frame exists
  assign commit = wrap | (state_q == IDLE);

  always_comb begin
    act_bcd_d  = act_bcd_q;
    act_dp_d   = act_dp_q;
    pend_bcd_d = pend_bcd_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    if (commit) begin
      if (load) begin
        act_bcd_d = bcd_in;
        act_dp_d  = dp_in;
      end else if (pend_q) begin
        act_bcd_d = pend_bcd_q;
        act_dp_d  = pend_dp_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_bcd_d = bcd_in;
      pend_dp_d  = dp_in;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b0;
      an_q       <= '0;
      tick_q     <= 1'b0;
      act_bcd_q  <= '1;
      act_dp_q   <= '0;
      pend_bcd_q <= '1;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      tick_q     <= tick_d;
      act_bcd_q  <= act_bcd_d;
      act_dp_q   <= act_dp_d;
      pend_bcd_q <= pend_bcd_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire
